idct4_mac: RTL and testbench
============================

Name: idct4_mac

Overview:
- Row stage of the HEVC 4-point inverse transform. Sits directly upstream of the post-transform shifter.
- Collects 4 signed coefficients from one of FLUX input streams, multiplies them by the fixed HEVC 4x4 DCT matrix and emits 4 accumulated sums. Each sum already includes the rounding offset, so downstream only shifts right by SHIFT_NUM.
- Uses the same multi-flux FIFO actor interfaces as the rest of the dataflow.

Parameters:
- DATA_IN_WIDTH, 16: signed input coefficient width.
- DATA_WIDTH, 27: signed output sum width; must match the downstream shifter's DATA_WIDTH.
- FLUX, 2: number of input data streams.
- SHIFT_NUM, 11: downstream shift amount; rounding offset is 1<<(SHIFT_NUM-1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- read_port.empty  input  FLUX  per-flux empty flag of the input FIFOs.
- read_port.dout  input  DATA_IN_WIDTH  first-word-fall-through data of the flux currently being read.
- read_port.read  output  FLUX  per-flux read strobe; at most one bit high.
- write_port.full  input  1  output FIFO full flag.
- write_port.din  output  DATA_WIDTH  signed sum plus rounding offset.
- write_port.write  output  1  output write strobe.

Behaviour:
- Single clock (clk). Reset is synchronous, active-high (rst).
- Reset values: state=IDLE, cnt=0, lock_tag=0, x[0..3]=0, read_port.read=0, write_port.write=0.
- Output din when write=0 is don't-care ('x).
- IDLE:
  - Select the highest-index flux i with empty[i]==0, using the same priority order as the downstream shifter.
  - If one exists: register lock_tag=i, read[i]=1 in the same cycle, x[0]<=dout, cnt<=1, go to LOAD.
  - If all flux are empty: stay in IDLE.
- LOAD:
  - Only lock_tag is read; other flux are ignored even if non-empty.
  - If empty[lock_tag]==0: read[lock_tag]=1, x[cnt]<=dout, cnt<=cnt+1.
  - When the 4th sample is captured (cnt==3): cnt<=0, go to EMIT.
  - Empty lock_tag FIFO: wait. The group is never abandoned and there is no timeout.
- EMIT:
  - Row n=cnt (0..3): din = sum_k M[k][n]*x[k] + (1<<(SHIFT_NUM-1)), sign-extended to DATA_WIDTH.
  - M rows are: [64,64,64,64], [83,36,-36,-83], [64,-64,-64,64], [36,-83,83,-36].
  - Output is combinational from registered x and cnt: write=1 iff full==0.
  - On a write: cnt<=cnt+1. After n=3 is written: cnt<=0, go to IDLE.
  - full==1: hold n, write=0.
- No read occurs in EMIT; no write occurs in IDLE or LOAD.
- Best-case throughput: 8 cycles per group (4 reads + 4 writes).
- Arithmetic:
  - Products are DATA_IN_WIDTH+8 bits signed.
  - Worst-case |sum| is 256*2^15 = 2^23; with the offset this fits in 25 bits, so DATA_WIDTH>=25 is guaranteed and no saturation logic is needed.
  - Multiplication by constants is written as signed multiply; synthesis may reduce it to shift/add.
- Boundaries:
  - Reset mid-LOAD or mid-EMIT discards the partial group; no further read or write strobes after the reset edge.
  - Non-locked flux becoming non-empty during LOAD or EMIT has no effect until IDLE.
  - full toggling during EMIT: exactly one write per cycle with full==0, and no row is skipped or repeated.
  - FLUX=1: tag logic reduces to flux 0.

Decomposition:
- Package hevc_transform_pkg:
  - IDCT4_COEF matrix constant as a signed [7:0] 4x4 array.
  - State enum {IDLE, LOAD, EMIT}.
  - Function rnd_offset(SHIFT_NUM).
- Sub-module flux_priority_sel:
  - Combinational highest-index-non-empty selector; outputs tag and valid.
  - Reusable by the shifter and the other multi-flux actors.

Test Plan:
- Basic:
  - Stimulus: flux0 supplies 1,0,0,0; full=0.
  - Required response: writes 1088,1088,1088,1088 on 4 consecutive cycles after the 4th read.
- Odd-row response:
  - Stimulus: flux0 supplies 0,1,0,0.
  - Required response: 1107, 1060, 988, 941.
- Priority and lock:
  - Stimulus: flux0 and flux1 both non-empty at IDLE; flux1 holds -1,0,0,0.
  - Required response: all 4 reads on read[1], read[0] never asserted; outputs 960 x4. The flux0 group follows.
- Backpressure:
  - Stimulus: x=0,0,0,1; full=1 for 3 cycles at row 1.
  - Required response: sequence 1060, 941, 1107, 988 unbroken; write=0 while full=1.
- Starvation:
  - Stimulus: flux1 empties after 2 samples while flux0 is full.
  - Required response: module waits on flux1 with no read[0]; resumes when flux1 refills.
- Reset:
  - Stimulus: rst pulsed mid-EMIT after row 1.
  - Required response: next cycle write=0, read=0, state IDLE; a fresh group produces correct results.

Source files
------------

// File: rtl/hevc_transform_pkg.sv
// Shared constants and helpers for the HEVC inverse-transform actors.
package hevc_transform_pkg;

    // Actor FSM encoding; kept as plain constants so older blocks can share it.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t EMIT = 2'd2;

    // HEVC 4-point DCT basis. Row k weights input sample x[k]; column n is output row n.
    localparam logic signed [7:0] IDCT4_COEF [4][4] = '{
        '{ 8'sd64,  8'sd64,  8'sd64,  8'sd64},
        '{ 8'sd83,  8'sd36, -8'sd36, -8'sd83},
        '{ 8'sd64, -8'sd64, -8'sd64,  8'sd64},
        '{ 8'sd36, -8'sd83,  8'sd83, -8'sd36}
    };

    // Rounding offset that makes the downstream right-shift round to nearest.
    function automatic int rnd_offset(input int shift_num);
        return 1 << (shift_num - 1);
    endfunction

endpackage

// File: rtl/flux_priority_sel.sv
// Picks the highest-index non-empty input stream. Shared by all multi-flux actors
// so that every stage of the dataflow agrees on the same priority order.
module flux_priority_sel #(
    parameter int FLUX  = 2,
    parameter int TAG_W = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic [FLUX-1:0]  empty,
    output logic [TAG_W-1:0] tag,
    output logic             valid
);

    // Ascending scan: the last non-empty index seen wins, i.e. highest index.
    always_comb begin
        tag   = '0;
        valid = 1'b0;
        for (int i = 0; i < FLUX; i++) begin
            if (!empty[i]) begin
                tag   = TAG_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/idct4_mac.sv
// Row stage of the HEVC 4-point inverse transform: gathers 4 coefficients from one
// locked input stream, then emits the 4 matrix-product rows (rounding offset included).
module idct4_mac
    import hevc_transform_pkg::*;
#(
    parameter int DATA_IN_WIDTH = 16,
    parameter int DATA_WIDTH    = 27,
    parameter int FLUX          = 2,
    parameter int SHIFT_NUM     = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLUX-1:0]          read_port_empty,
    input  logic [DATA_IN_WIDTH-1:0] read_port_dout,
    output logic [FLUX-1:0]          read_port_read,
    input  logic                     write_port_full,
    output logic [DATA_WIDTH-1:0]    write_port_din,
    output logic                     write_port_write
);

    localparam int TAG_W = (FLUX > 1) ? $clog2(FLUX) : 1;
    localparam int PW    = DATA_IN_WIDTH + 8;
    localparam int RND   = rnd_offset(SHIFT_NUM);

    state_t                          state;
    logic [1:0]                      cnt;
    logic [TAG_W-1:0]                lock_tag;
    logic signed [DATA_IN_WIDTH-1:0] x [4];

    logic [TAG_W-1:0]                sel_tag;
    logic                            sel_valid;
    logic                            lock_avail;
    logic signed [PW-1:0]            prod [4];
    logic signed [DATA_WIDTH-1:0]    sum;

    flux_priority_sel #(
        .FLUX  (FLUX),
        .TAG_W (TAG_W)
    ) u_sel (
        .empty (read_port_empty),
        .tag   (sel_tag),
        .valid (sel_valid)
    );

    assign lock_avail = !read_port_empty[lock_tag];

    // One constant multiply per tap; coefficient column chosen by the row being emitted.
    for (genvar k = 0; k < 4; k++) begin : g_tap
        assign prod[k] = PW'(x[k]) * PW'(IDCT4_COEF[k][cnt]);
    end

    // Row sum with the rounding offset folded in; |sum| <= 2^23 so no saturation needed.
    always_comb begin
        sum = DATA_WIDTH'(RND);
        for (int k = 0; k < 4; k++) begin
            sum = sum + DATA_WIDTH'(prod[k]);
        end
    end

    assign write_port_din = sum;

    // Strobes are gated by reset so nothing is popped or pushed during a reset cycle.
    always_comb begin
        read_port_read   = '0;
        write_port_write = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    if (sel_valid)  read_port_read[sel_tag]  = 1'b1;
                LOAD:    if (lock_avail) read_port_read[lock_tag] = 1'b1;
                EMIT:    write_port_write = !write_port_full;
                default: ;
            endcase
        end
    end

    // Group FSM: lock a stream, capture 4 samples, emit 4 rows, return to arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            lock_tag <= '0;
            for (int k = 0; k < 4; k++) x[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        lock_tag <= sel_tag;
                        x[0]     <= read_port_dout;
                        cnt      <= 2'd1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (lock_avail) begin
                        x[cnt] <= read_port_dout;
                        cnt    <= cnt + 2'd1;
                        if (cnt == 2'd3) state <= EMIT;
                    end
                end
                EMIT: begin
                    if (!write_port_full) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idct4_mac.sv
// Bench for idct4_mac: queue-based input FIFOs, group-of-4 reference model,
// directed scenarios followed by randomized traffic with random backpressure.
module tb_idct4_mac;

    localparam int DIW  = 16;
    localparam int DW   = 27;
    localparam int FLUX = 2;
    localparam int SH   = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic [FLUX-1:0] empty;
    logic [FLUX-1:0] rd;
    logic [DIW-1:0]  dout, d0, d1;
    logic            full;
    logic            wr;
    logic [DW-1:0]   din;

    always #5 clk = ~clk;

    // FWFT data of whichever stream is being read.
    assign dout = rd[1] ? d1 : d0;

    idct4_mac #(
        .DATA_IN_WIDTH (DIW),
        .DATA_WIDTH    (DW),
        .FLUX          (FLUX),
        .SHIFT_NUM     (SH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .read_port_empty  (empty),
        .read_port_dout   (dout),
        .read_port_read   (rd),
        .write_port_full  (full),
        .write_port_din   (din),
        .write_port_write (wr)
    );

    int M [4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83},
                     '{64, -64, -64, 64}, '{36, -83, 83, -36}};

    int     checks = 0;
    int     errors = 0;
    longint q0[$], q1[$], exp_q[$], dir_q[$];
    longint grp [4];
    int     grp_n = 0, grp_flux = 0, wr_in_grp = 0;
    int     n_rd0 = 0, n_rd1 = 0, n_wr = 0;
    int     rd_hist [16], wr_hist [16];
    int     cyc = 0;

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint ref_row(input int n);
        longint s = longint'(1) << (SH - 1);
        for (int k = 0; k < 4; k++) s += M[k][n] * grp[k];
        return s;
    endfunction

    function automatic longint rv();
        int sel = $urandom_range(0, 7);
        if (sel == 0) return -32768;
        if (sel == 1) return 32767;
        return longint'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic push4(input int f, input longint a, input longint b, input longint c, input longint e);
        if (f == 1) begin q1.push_back(a); q1.push_back(b); q1.push_back(c); q1.push_back(e); end
        else        begin q0.push_back(a); q0.push_back(b); q0.push_back(c); q0.push_back(e); end
    endtask

    task automatic upd();
        empty[0] = (q0.size() == 0);
        empty[1] = (q1.size() == 0);
        d0 = (q0.size() != 0) ? DIW'(q0[0]) : '0;
        d1 = (q1.size() != 0) ? DIW'(q1[0]) : '0;
    endtask

    // One clock: present inputs, sample outputs mid-cycle, update FIFOs/model, advance.
    task automatic cycle();
        longint obs, v, tmp;
        int f;
        upd();
        #1;
        if (rst) begin
            chk("rst_read", rd, 0);
            chk("rst_write", wr, 0);
            exp_q.delete();
            dir_q.delete();
            grp_n = 0;
            wr_in_grp = 0;
        end else begin
            if (rd != 0 || wr) chk("one_strobe", $countones(rd) + int'(wr), 1);
            if (rd != 0) begin
                f = rd[1] ? 1 : 0;
                v = $signed(dout);
                chk("rd_nonempty", empty[f], 0);
                if (f == 1) begin n_rd1++; if (q1.size() != 0) tmp = q1.pop_front(); end
                else        begin n_rd0++; if (q0.size() != 0) tmp = q0.pop_front(); end
                if (grp_n == 0) grp_flux = f;
                else chk("lock", f, grp_flux);
                grp[grp_n] = v;
                grp_n++;
                if (grp_n == 4) begin
                    for (int n = 0; n < 4; n++) exp_q.push_back(ref_row(n));
                    grp_n = 0;
                end
            end
            if (wr) begin
                n_wr++;
                obs = $signed(din);
                chk("wr_when_full", full, 0);
                chk("wr_expected", longint'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("din_model", obs, exp_q.pop_front());
                if (dir_q.size() != 0) chk("din_directed", obs, dir_q.pop_front());
                wr_in_grp = (wr_in_grp + 1) % 4;
            end
        end
        if (cyc < 16) begin
            rd_hist[cyc] = (rd != 0) ? 1 : 0;
            wr_hist[cyc] = int'(wr);
        end
        cyc++;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_wr(input int k, input int budget);
        int b = budget;
        while (wr_in_grp != k && b > 0) begin
            cycle();
            b--;
        end
        chk("wait_wr_timeout", wr_in_grp, k);
    endtask

    initial begin
        int f, b;
        rst = 1'b1; full = 1'b0; d0 = '0; d1 = '0; empty = '1;
        @(posedge clk);
        #2;

        // Reset state
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        chk("idle_read", rd, 0);
        chk("idle_write", wr, 0);

        // Basic: 1,0,0,0 -> 1088 x4, reads on cycles 0..3, writes on 4..7
        push4(0, 1, 0, 0, 0);
        repeat (4) dir_q.push_back(1088);
        cyc = 0;
        repeat (10) cycle();
        for (int i = 0; i < 4; i++) chk("basic_rd_slot", rd_hist[i], 1);
        for (int i = 4; i < 8; i++) chk("basic_wr_slot", wr_hist[i], 1);
        chk("basic_quiet", wr_hist[8], 0);
        chk("basic_done", dir_q.size(), 0);

        // Odd-row response
        push4(0, 0, 1, 0, 0);
        dir_q.push_back(1107); dir_q.push_back(1060); dir_q.push_back(988); dir_q.push_back(941);
        repeat (10) cycle();
        chk("odd_done", dir_q.size(), 0);

        // Priority and lock: flux1 wins, flux0 untouched until flux1 group is done
        push4(0, 1, 0, 0, 0);
        push4(1, -1, 0, 0, 0);
        repeat (4) dir_q.push_back(960);
        repeat (4) dir_q.push_back(1088);
        n_rd0 = 0; n_rd1 = 0;
        repeat (8) cycle();
        chk("prio_no_rd0", n_rd0, 0);
        chk("prio_rd1", n_rd1, 4);
        repeat (10) cycle();
        chk("prio_rd0_after", n_rd0, 4);
        chk("prio_done", dir_q.size(), 0);

        // Backpressure at row 1 for 3 cycles
        push4(0, 0, 0, 0, 1);
        dir_q.push_back(1060); dir_q.push_back(941); dir_q.push_back(1107); dir_q.push_back(988);
        wait_wr(1, 20);
        full = 1'b1;
        n_wr = 0;
        repeat (3) cycle();
        chk("bp_no_wr", n_wr, 0);
        full = 1'b0;
        repeat (5) cycle();
        chk("bp_wr", n_wr, 3);
        chk("bp_done", dir_q.size(), 0);

        // Starvation: flux1 stalls after 2 samples while flux0 holds a full group
        push4(0, rv(), rv(), rv(), rv());
        q1.push_back(rv()); q1.push_back(rv());
        n_rd0 = 0; n_rd1 = 0; n_wr = 0;
        repeat (8) cycle();
        chk("starve_no_rd0", n_rd0, 0);
        chk("starve_rd1", n_rd1, 2);
        chk("starve_no_wr", n_wr, 0);
        q1.push_back(rv()); q1.push_back(rv());
        repeat (20) cycle();
        chk("starve_rd1_all", n_rd1, 4);
        chk("starve_rd0_all", n_rd0, 4);
        chk("starve_wr_all", n_wr, 8);
        chk("starve_exp_empty", exp_q.size(), 0);

        // Reset mid-EMIT after row 1, then a fresh group
        push4(0, rv(), rv(), rv(), rv());
        wait_wr(2, 20);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_read", rd, 0);
        chk("post_rst_write", wr, 0);
        push4(0, 1, 0, 0, 0);
        repeat (4) dir_q.push_back(1088);
        repeat (10) cycle();
        chk("post_rst_done", dir_q.size(), 0);
        chk("post_rst_exp_empty", exp_q.size(), 0);

        // Randomized traffic with random backpressure
        repeat (800) begin
            if ($urandom_range(0, 2) == 0) begin
                f = $urandom_range(0, 1);
                if ((f == 1 ? q1.size() : q0.size()) < 8) push4(f, rv(), rv(), rv(), rv());
            end
            full = ($urandom_range(0, 3) == 0);
            cycle();
        end
        full = 1'b0;
        b = 400;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 || grp_n != 0) && b > 0) begin
            cycle();
            b--;
        end
        chk("drain_exp", exp_q.size(), 0);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
